// File: rtl/vga_scan_compositor.sv
// vga_scan_compositor
//   Raster side of the overlay path. Runs the 640x480@60 horizontal and vertical
//   counters, exposes the current pixel position to the combinational overlay
//   generators, and registers the composed colour together with the sync pulses.
//   This keeps the RGB pins and sync pins aligned on the same clock edge.
//
// Ports
//   clk          pixel clock, one pixel per cycle
//   rst          synchronous, active-high reset
//   x, y         current h/v counter values (combinational from the counter registers)
//   active       high while (x,y) is inside the visible area
//   overlay_rgb  overlay colour for (x,y); KEY_RGB means transparent
//   bg_rgb       background colour for (x,y), used where the overlay is transparent
//   hsync        registered, active-low horizontal sync
//   vsync        registered, active-low vertical sync
//   rgb          registered colour {R1,R0,G1,G0,B1,B0}
//   frame_start  registered pulse, coincident with pixel (0,0) on rgb
//   frame_cnt    frame counter, wraps 255->0
module vga_scan_compositor #(
  parameter int          H_ACTIVE = 640,
  parameter int          H_FP     = 16,
  parameter int          H_SYNC   = 96,
  parameter int          H_BP     = 48,
  parameter int          V_ACTIVE = 480,
  parameter int          V_FP     = 10,
  parameter int          V_SYNC   = 2,
  parameter int          V_BP     = 33,
  parameter logic [5:0]  KEY_RGB  = 6'b100001
) (
  input  logic       clk,
  input  logic       rst,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  input  logic [5:0] overlay_rgb,
  input  logic [5:0] bg_rgb,
  output logic       hsync,
  output logic       vsync,
  output logic [5:0] rgb,
  output logic       frame_start,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_START   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_START   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_ACTIVE + V_FP + V_SYNC);

  // Key substitution and blanking: transparent overlay pixels show the
  // background, and nothing is driven outside the visible area.
  function automatic logic [5:0] compose_rgb(input logic       act,
                                             input logic [5:0] ovl,
                                             input logic [5:0] bg);
    if (!act)
      return 6'b000000;
    else if (ovl == KEY_RGB)
      return bg;
    else
      return ovl;
  endfunction

  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic [7:0] frame_cnt_r;
  logic       active_p0;
  logic       hsync_p1;
  logic       vsync_p1;
  logic [5:0] rgb_p1;
  logic       frame_start_p1;

  // Stage p0: raster counters; pixel position is presented to the overlays.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_cnt_r <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      if (v_cnt == V_LAST) begin
        v_cnt       <= '0;
        frame_cnt_r <= frame_cnt_r + 8'd1;
      end else begin
        v_cnt <= v_cnt + 10'd1;
      end
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  assign active_p0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);

  // Stage p1: colour and syncs registered together so the pins stay aligned.
  // Reset forces the sync pins inactive, so a pulse in flight is cut off.
  always_ff @(posedge clk) begin
    if (rst) begin
      hsync_p1       <= 1'b1;
      vsync_p1       <= 1'b1;
      rgb_p1         <= 6'b000000;
      frame_start_p1 <= 1'b0;
    end else begin
      hsync_p1       <= !((h_cnt >= HS_START) && (h_cnt < HS_END));
      vsync_p1       <= !((v_cnt >= VS_START) && (v_cnt < VS_END));
      rgb_p1         <= compose_rgb(active_p0, overlay_rgb, bg_rgb);
      frame_start_p1 <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
    end
  end

  assign x           = h_cnt;
  assign y           = v_cnt;
  assign active      = active_p0;
  assign hsync       = hsync_p1;
  assign vsync       = vsync_p1;
  assign rgb         = rgb_p1;
  assign frame_start = frame_start_p1;
  assign frame_cnt   = frame_cnt_r;

endmodule

// File: tb/tb_vga_scan_compositor.sv
// Testbench for vga_scan_compositor.
//   u_full runs the standard 640x480 timing (reset, line timing, colour path,
//   horizontal blanking). u_small uses a shrunken 32x15 raster so that vertical
//   blanking, whole frames and a mid-frame reset fit in a short run.
//   Small raster: h total 32 (hsync low for h 20..25), v total 15
//   (vsync low for v 8..10), frame = 480 cycles.
module tb_vga_scan_compositor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] overlay_rgb = 6'b000000;
  logic [5:0] bg_rgb = 6'b000000;

  logic [9:0] f_x, f_y, s_x, s_y;
  logic       f_active, f_hsync, f_vsync, f_frame_start;
  logic       s_active, s_hsync, s_vsync, s_frame_start;
  logic [5:0] f_rgb, s_rgb;
  logic [7:0] f_frame_cnt, s_frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;  // samples since the first edge after reset release

  always #5 clk = ~clk;

  vga_scan_compositor u_full (
    .clk(clk), .rst(rst), .x(f_x), .y(f_y), .active(f_active),
    .overlay_rgb(overlay_rgb), .bg_rgb(bg_rgb), .hsync(f_hsync), .vsync(f_vsync),
    .rgb(f_rgb), .frame_start(f_frame_start), .frame_cnt(f_frame_cnt)
  );

  vga_scan_compositor #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(6),  .V_FP(2), .V_SYNC(3), .V_BP(4)
  ) u_small (
    .clk(clk), .rst(rst), .x(s_x), .y(s_y), .active(s_active),
    .overlay_rgb(overlay_rgb), .bg_rgb(bg_rgb), .hsync(s_hsync), .vsync(s_vsync),
    .rgb(s_rgb), .frame_start(s_frame_start), .frame_cnt(s_frame_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    rst = 1'b1; overlay_rgb = 6'b111111; bg_rgb = 6'b111111;
    repeat (3) tick();
    checks++; if (f_hsync !== 1'b1) begin errors++; $display("FAIL rst_hsync got %b exp 1", f_hsync); end
    checks++; if (f_vsync !== 1'b1) begin errors++; $display("FAIL rst_vsync got %b exp 1", f_vsync); end
    checks++; if (f_rgb !== 6'b000000) begin errors++; $display("FAIL rst_rgb got %b exp 000000", f_rgb); end
    checks++; if (f_x !== 10'd0) begin errors++; $display("FAIL rst_x got %0d exp 0", f_x); end
    checks++; if (f_y !== 10'd0) begin errors++; $display("FAIL rst_y got %0d exp 0", f_y); end
    checks++; if (f_frame_cnt !== 8'd0) begin errors++; $display("FAIL rst_frame_cnt got %0d exp 0", f_frame_cnt); end
    checks++; if (f_frame_start !== 1'b0) begin errors++; $display("FAIL rst_frame_start got %b exp 0", f_frame_start); end
    checks++; if (f_active !== 1'b1) begin errors++; $display("FAIL rst_active got %b exp 1", f_active); end
    // Release with a non-keyed colour for pixel (0,0).
    overlay_rgb = 6'b010101; bg_rgb = 6'b000000;
    rst = 1'b0;
    tick();
    cyc = 0;
    checks++; if (f_frame_start !== 1'b1) begin errors++; $display("FAIL rel_frame_start got %b exp 1", f_frame_start); end
    checks++; if (s_frame_start !== 1'b1) begin errors++; $display("FAIL rel_small_frame_start got %b exp 1", s_frame_start); end
    checks++; if (f_rgb !== 6'b010101) begin errors++; $display("FAIL rel_rgb00 got %b exp 010101", f_rgb); end
    checks++; if (f_x !== 10'd1) begin errors++; $display("FAIL rel_x got %0d exp 1", f_x); end
    checks++; if (f_frame_cnt !== 8'd0) begin errors++; $display("FAIL rel_frame_cnt got %0d exp 0", f_frame_cnt); end
    tick();
    checks++; if (f_frame_start !== 1'b0) begin errors++; $display("FAIL rel_frame_start_drop got %b exp 0", f_frame_start); end
  endtask

  // hsync on the full raster: sample cyc reflects h_cnt == cyc (mod 800) before
  // the edge, so low samples are cyc 656..751 and the next line starts at 1456.
  task automatic test_hsync_line();
    int   first_low  = -1;
    int   second_low = -1;
    int   lows       = 0;
    logic prev       = 1'b1;
    logic vs_seen_low = 1'b0;
    for (int i = 0; i < 1699; i++) begin
      tick();
      if (!f_hsync) begin
        if (prev) begin
          if (first_low < 0) first_low = cyc;
          else if (second_low < 0) second_low = cyc;
        end
        if (second_low < 0) lows++;
      end
      if (!f_vsync) vs_seen_low = 1'b1;
      prev = f_hsync;
    end
    checks++; if (first_low !== 656) begin errors++; $display("FAIL hs_first_low got %0d exp 656", first_low); end
    checks++; if (lows !== 96) begin errors++; $display("FAIL hs_width got %0d exp 96", lows); end
    checks++; if (second_low !== 1456) begin errors++; $display("FAIL hs_period_start got %0d exp 1456", second_low); end
    checks++; if (vs_seen_low !== 1'b0) begin errors++; $display("FAIL vs_early got %b exp 0", vs_seen_low); end
    checks++; if (f_x !== 10'd101) begin errors++; $display("FAIL line_x got %0d exp 101", f_x); end
    checks++; if (f_y !== 10'd2) begin errors++; $display("FAIL line_y got %0d exp 2", f_y); end
  endtask

  task automatic test_colour();
    checks++; if (f_active !== 1'b1) begin errors++; $display("FAIL col_active got %b exp 1", f_active); end
    overlay_rgb = 6'b100001; bg_rgb = 6'b000011;
    tick();
    checks++; if (f_rgb !== 6'b000011) begin errors++; $display("FAIL col_key_bg got %b exp 000011", f_rgb); end
    overlay_rgb = 6'b110110; bg_rgb = 6'b000011;
    tick();
    checks++; if (f_rgb !== 6'b110110) begin errors++; $display("FAIL col_overlay got %b exp 110110", f_rgb); end
    overlay_rgb = 6'b100001; bg_rgb = 6'b101010;
    tick();
    checks++; if (f_rgb !== 6'b101010) begin errors++; $display("FAIL col_key_bg2 got %b exp 101010", f_rgb); end
    overlay_rgb = 6'b100000; bg_rgb = 6'b010101;
    tick();
    checks++; if (f_rgb !== 6'b100000) begin errors++; $display("FAIL col_near_key got %b exp 100000", f_rgb); end
  endtask

  task automatic test_blanking();
    overlay_rgb = 6'b111111; bg_rgb = 6'b111111;
    for (int i = 0; i < 800 && f_x !== 10'd640; i++) tick();
    checks++; if (f_x !== 10'd640) begin errors++; $display("FAIL wait_h640 got %0d exp 640", f_x); end
    checks++; if (f_active !== 1'b0) begin errors++; $display("FAIL blank_h640_active got %b exp 0", f_active); end
    tick();
    checks++; if (f_rgb !== 6'b000000) begin errors++; $display("FAIL blank_h640_rgb got %b exp 000000", f_rgb); end
    for (int i = 0; i < 800 && f_x !== 10'd799; i++) tick();
    checks++; if (f_active !== 1'b0) begin errors++; $display("FAIL blank_h799_active got %b exp 0", f_active); end
    tick();
    checks++; if (f_rgb !== 6'b000000) begin errors++; $display("FAIL blank_h799_rgb got %b exp 000000", f_rgb); end
    checks++; if (f_active !== 1'b1) begin errors++; $display("FAIL line_start_active got %b exp 1", f_active); end
    tick();
    checks++; if (f_rgb !== 6'b111111) begin errors++; $display("FAIL line_start_rgb got %b exp 111111", f_rgb); end
    // Vertical blanking on the small raster, inside the visible column range.
    for (int i = 0; i < 600 && !(s_y === 10'd6 && s_x === 10'd3); i++) tick();
    checks++; if (s_y !== 10'd6 || s_x !== 10'd3) begin errors++; $display("FAIL wait_v6 got x=%0d y=%0d exp x=3 y=6", s_x, s_y); end
    checks++; if (s_active !== 1'b0) begin errors++; $display("FAIL vblank_active got %b exp 0", s_active); end
    tick();
    checks++; if (s_rgb !== 6'b000000) begin errors++; $display("FAIL vblank_rgb got %b exp 000000", s_rgb); end
  endtask

  // Small raster frame: from a frame_start sample, vsync is low at offsets
  // 256..351 (lines 8..10 x 32) and the next frame_start is at offset 480.
  task automatic test_frame();
    int fs_off   = -1;
    int vs_first = -1;
    int vs_lows  = 0;
    int t0;
    for (int i = 0; i < 600 && s_frame_start !== 1'b1; i++) tick();
    checks++; if (s_frame_start !== 1'b1) begin errors++; $display("FAIL wait_frame_start got %b exp 1", s_frame_start); end
    checks++; if ((cyc % 480) !== 0) begin errors++; $display("FAIL frame_start_phase got %0d exp 0", cyc % 480); end
    t0 = cyc;
    for (int i = 1; i <= 480; i++) begin
      tick();
      if (!s_vsync) begin
        vs_lows++;
        if (vs_first < 0) vs_first = i;
      end
      if (s_frame_start && fs_off < 0) fs_off = i;
    end
    checks++; if (vs_lows !== 96) begin errors++; $display("FAIL vs_width got %0d exp 96", vs_lows); end
    checks++; if (vs_first !== 256) begin errors++; $display("FAIL vs_first got %0d exp 256", vs_first); end
    checks++; if (fs_off !== 480) begin errors++; $display("FAIL fs_period got %0d exp 480", fs_off); end
    checks++; if (s_frame_cnt !== 8'((t0 + 481) / 480)) begin errors++; $display("FAIL frame_cnt got %0d exp %0d", s_frame_cnt, (t0 + 481) / 480); end
    checks++; if (f_frame_cnt !== 8'd0) begin errors++; $display("FAIL full_frame_cnt got %0d exp 0", f_frame_cnt); end
  endtask

  // Reset while both sync pulses of the small raster are low (h=22, v=9).
  task automatic test_mid_reset();
    while (cyc < 3 * 480) tick();
    for (int i = 0; i < 600 && !(s_x === 10'd22 && s_y === 10'd9); i++) tick();
    checks++; if (s_x !== 10'd22 || s_y !== 10'd9) begin errors++; $display("FAIL wait_mid got x=%0d y=%0d exp x=22 y=9", s_x, s_y); end
    checks++; if (s_hsync !== 1'b0 || s_vsync !== 1'b0) begin errors++; $display("FAIL mid_syncs got hs=%b vs=%b exp 0 0", s_hsync, s_vsync); end
    checks++; if (s_frame_cnt !== 8'((cyc + 1) / 480)) begin errors++; $display("FAIL mid_frame_cnt got %0d exp %0d", s_frame_cnt, (cyc + 1) / 480); end
    rst = 1'b1;
    tick();
    checks++; if (s_x !== 10'd0 || s_y !== 10'd0) begin errors++; $display("FAIL mr_xy got x=%0d y=%0d exp 0 0", s_x, s_y); end
    checks++; if (s_frame_cnt !== 8'd0) begin errors++; $display("FAIL mr_frame_cnt got %0d exp 0", s_frame_cnt); end
    checks++; if (s_hsync !== 1'b1 || s_vsync !== 1'b1) begin errors++; $display("FAIL mr_syncs got hs=%b vs=%b exp 1 1", s_hsync, s_vsync); end
    checks++; if (s_rgb !== 6'b000000) begin errors++; $display("FAIL mr_rgb got %b exp 000000", s_rgb); end
    checks++; if (f_x !== 10'd0 || f_y !== 10'd0) begin errors++; $display("FAIL mr_full_xy got x=%0d y=%0d exp 0 0", f_x, f_y); end
    rst = 1'b0;
    tick();
    checks++; if (s_frame_start !== 1'b1) begin errors++; $display("FAIL mr_frame_start got %b exp 1", s_frame_start); end
    checks++; if (f_frame_start !== 1'b1) begin errors++; $display("FAIL mr_full_frame_start got %b exp 1", f_frame_start); end
    checks++; if (s_x !== 10'd1) begin errors++; $display("FAIL mr_x got %0d exp 1", s_x); end
    tick();
    checks++; if (s_frame_start !== 1'b0) begin errors++; $display("FAIL mr_frame_start_drop got %b exp 0", s_frame_start); end
    checks++; if (s_frame_cnt !== 8'd0) begin errors++; $display("FAIL mr_frame_cnt_hold got %0d exp 0", s_frame_cnt); end
  endtask

  initial begin
    test_reset();
    test_hsync_line();
    test_colour();
    test_blanking();
    test_frame();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

endmodule
